rot_share_arb: RTL

//  Round-robin arbiter that shares one 8-bit rotate-right unit among N_REQ requesters.

---
 rtl/rot_share_arb_pkg.sv | 37 +++
 rtl/rot_share_arb_if.sv | 29 ++
 rtl/rot_share_arb_barrel_shifter.sv | 20 ++
 rtl/rot_share_arb.sv | 95 +++++++++
 4 files changed

// File: rtl/rot_share_arb_pkg.sv
// Shared constants and the round-robin pick helper for rot_share_arb.
package rot_pkg;

  localparam int unsigned BYTE_W  = 8;
  localparam int unsigned AMT_W   = 3;
  localparam int unsigned MAX_REQ = 8;
  localparam int unsigned PTR_W   = 3;

  // One-hot grant of the first valid requester at or after ptr, wrapping at n.
  // The valid vector is laid out twice: the low copy is masked to indices >= ptr,
  // the high copy is unmasked, so the lowest set bit of the double-width vector
  // is the round-robin winner; its position is folded back modulo n.
  function automatic logic [MAX_REQ-1:0] rr_pick(input logic [MAX_REQ-1:0] valid,
                                                 input logic [PTR_W-1:0]   ptr,
                                                 input int unsigned        n);
    logic [2*MAX_REQ-1:0] dbl;
    logic [MAX_REQ-1:0]   gnt;
    logic                 found;
    dbl   = '0;
    gnt   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < MAX_REQ; i++) begin
      if (i < n) begin
        dbl[i]          = valid[i] && (i >= 32'(ptr));
        dbl[4'(i + n)]  = valid[i];
      end
    end
    for (int unsigned j = 0; j < 2 * MAX_REQ; j++) begin
      if (!found && dbl[j]) begin
        found             = 1'b1;
        gnt[3'(j % n)]    = 1'b1;
      end
    end
    return gnt;
  endfunction

endpackage

// File: rtl/rot_share_arb_if.sv
// Requester and consumer handshake bundle for rot_share_arb.
interface rot_share_arb_if #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned ID_W  = 2
);
  import rot_pkg::*;

  logic [N_REQ-1:0]        i_req_valid;
  logic [BYTE_W*N_REQ-1:0] i_req_data;
  logic [AMT_W*N_REQ-1:0]  i_req_amt;
  logic [N_REQ-1:0]        o_req_ready;
  logic                    o_valid;
  logic [BYTE_W-1:0]       o_data;
  logic [ID_W-1:0]         o_id;
  logic                    i_ready;

  // Arbiter side
  modport slave (
    input  i_req_valid, i_req_data, i_req_amt, i_ready,
    output o_req_ready, o_valid, o_data, o_id
  );

  // Requesters/consumer side
  modport master (
    output i_req_valid, i_req_data, i_req_amt, i_ready,
    input  o_req_ready, o_valid, o_data, o_id
  );

endinterface

// File: rtl/rot_share_arb_barrel_shifter.sv
// 8-bit rotate-right unit: result bit k = input bit (k + shift_amount) mod 8.
module barrel_shifter
  import rot_pkg::*;
(
  input  logic [AMT_W-1:0]  shift_amount,
  input  logic [BYTE_W-1:0] i_data,
  output logic [BYTE_W-1:0] o_data
);

  logic [BYTE_W-1:0] s1;
  logic [BYTE_W-1:0] s2;

  // Log-stage rotate by 1, 2, then 4.
  always_comb begin
    s1     = shift_amount[0] ? {i_data[0],   i_data[BYTE_W-1:1]} : i_data;
    s2     = shift_amount[1] ? {s1[1:0],     s1[BYTE_W-1:2]}     : s1;
    o_data = shift_amount[2] ? {s2[3:0],     s2[BYTE_W-1:4]}     : s2;
  end

endmodule

// File: rtl/rot_share_arb.sv
// Round-robin arbiter sharing one rotate-right unit among N_REQ requesters,
// with a single registered output stage drained by valid/ready.
module rot_share_arb
  import rot_pkg::*;
#(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned ID_W  = 2
) (
  input logic            i_clk,
  input logic            i_rstn,
  rot_share_arb_if.slave bus
);

  logic                 o_valid_q, o_valid_d;
  logic [BYTE_W-1:0]    o_data_q,  o_data_d;
  logic [ID_W-1:0]      o_id_q,    o_id_d;
  logic [ID_W-1:0]      rr_ptr_q,  rr_ptr_d;

  logic                 space;
  logic [MAX_REQ-1:0]   valid_pad;
  logic [MAX_REQ-1:0]   pick;
  logic [N_REQ-1:0]     grant;
  logic                 accept;
  logic [BYTE_W-1:0]    sel_data;
  logic [AMT_W-1:0]     sel_amt;
  logic [ID_W-1:0]      sel_id;
  logic [BYTE_W-1:0]    rot_data;

  // Grant: round-robin pick, suppressed when the output stage has no room or in reset.
  always_comb begin
    space                 = !o_valid_q || bus.i_ready;
    valid_pad             = '0;
    valid_pad[N_REQ-1:0]  = bus.i_req_valid;
    pick                  = rr_pick(valid_pad, PTR_W'(rr_ptr_q), N_REQ);
    grant                 = (space && i_rstn) ? pick[N_REQ-1:0] : '0;
    accept                = |grant;
  end

  // Operand mux from the granted requester; zero grant yields data 0, amt 0.
  always_comb begin
    sel_data = '0;
    sel_amt  = '0;
    sel_id   = '0;
    for (int unsigned n = 0; n < N_REQ; n++) begin
      if (grant[n]) begin
        sel_data = bus.i_req_data[BYTE_W*n +: BYTE_W];
        sel_amt  = bus.i_req_amt[AMT_W*n +: AMT_W];
        sel_id   = ID_W'(n);
      end
    end
  end

  barrel_shifter u_rot (
    .shift_amount (sel_amt),
    .i_data       (sel_data),
    .o_data       (rot_data)
  );

  // Next state of the output stage and pointer: load on accept, clear on drain, else hold.
  always_comb begin
    o_valid_d = o_valid_q;
    o_data_d  = o_data_q;
    o_id_d    = o_id_q;
    rr_ptr_d  = rr_ptr_q;
    if (accept) begin
      o_valid_d = 1'b1;
      o_data_d  = rot_data;
      o_id_d    = sel_id;
      rr_ptr_d  = (32'(sel_id) == N_REQ - 1) ? '0 : sel_id + ID_W'(1);
    end else if (o_valid_q && bus.i_ready) begin
      o_valid_d = 1'b0;
    end
  end

  // Output register and round-robin pointer.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      o_valid_q <= 1'b0;
      o_data_q  <= '0;
      o_id_q    <= '0;
      rr_ptr_q  <= '0;
    end else begin
      o_valid_q <= o_valid_d;
      o_data_q  <= o_data_d;
      o_id_q    <= o_id_d;
      rr_ptr_q  <= rr_ptr_d;
    end
  end

  assign bus.o_req_ready = grant;
  assign bus.o_valid     = o_valid_q;
  assign bus.o_data      = o_data_q;
  assign bus.o_id        = o_id_q;

endmodule
